t07_mem_arbiter: RTL and testbench
==================================

# t07_mem_arbiter

Shares the single external memory-bus port between the CPU instruction-fetch requester and the load/store data requester. It arbitrates between them and drives address, write data and the `rwi` command onto the bus. It tracks completion with the bus `busy` falling-edge handshake and returns read data to the granted requester with a one-cycle done pulse. A watchdog aborts transactions whose `busy` never completes, and a starvation counter guarantees fetch progress under back-to-back data traffic.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles spent in WAIT before a transaction is aborted with error.
- `STARVE_LIMIT`, 4: consecutive data grants, taken while fetch is pending, after which fetch wins.

Ports:
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `busy_i` in 1: bus busy; a high→low transition marks transaction completion.
- `rdata_i` in 32: bus read data, valid in the cycle `busy_i` falls.
- `f_req_i` in 1, `f_addr_i` in 32: fetch request and its address.
- `f_done_o` out 1, `f_rdata_o` out 32: fetch completion pulse and instruction word.
- `d_req_i` in 1, `d_we_i` in 1, `d_addr_i` in 32, `d_wdata_i` in 32: data request, 1=store, address, store data.
- `d_done_o` out 1, `d_rdata_o` out 32: data completion pulse and load data.
- `err_o` out 1: qualifies the current done pulse as a timeout abort.
- `addr_o` out 32, `wdata_o` out 32: bus address and write data.
- `rwi_o` out 2: bus command. 00=idle, 10=read, 01=write, 11=fetch.
- `sel_o` out 1: address-mux control. 1=fetch owns bus, 0=data owns bus.
- `state_o` out 3: current FSM state, for debug.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Samples requests only in this state.
  - Grant rule:
    - Only one requester active: grant it.
    - Both active: grant data, unless `starve_cnt == STARVE_LIMIT`, in which case grant fetch.
  - On a grant, latch address, we and wdata into transaction registers; go to ISSUE.
- **ISSUE** (1 cycle): drive the latched `addr_o`, `wdata_o` and `rwi_o` (11 fetch, 10 load, 01 store) and the matching `sel_o`; go to WAIT.
- **WAIT**
  - Keep driving the ISSUE values unchanged.
  - Falling edge detected (`prev_busy & ~busy_i`): capture `rdata_i` (loads and fetches only; stores capture 0); go to RESP with err=0.
  - Watchdog `to_cnt` reaches `TIMEOUT-1` without an edge: go to RESP with err=1 and rdata=0.
- **RESP** (1 cycle)
  - `rwi_o=00`.
  - Pulse the granted requester's done output; drive its rdata output; drive `err_o`.
  - Go to IDLE.
- `f_rdata_o` and `d_rdata_o` hold their last value until the next RESP for that port.
- Starvation counter `starve_cnt`:
  - Increments (saturating at `STARVE_LIMIT`) on each data grant made while `f_req_i` is high.
  - Clears on any fetch grant.
- Requester contract:
  - Hold req and operands until done.
  - Deassert req in the cycle after done.
  - A req still high in the IDLE cycle after RESP is treated as a new request.
- Defaults: `addr_o` and `wdata_o` are 0 in IDLE and RESP; `sel_o` is 1 in IDLE.

## Timing
- Reset values: state IDLE; `rwi_o`=00, `addr_o`=0, `wdata_o`=0, `sel_o`=1, `f_done_o`=`d_done_o`=`err_o`=0, `f_rdata_o`=`d_rdata_o`=0, `starve_cnt`=0, `to_cnt`=0, `prev_busy`=0.
- Latency, with req high in IDLE at cycle 0:
  - ISSUE at cycle 1, WAIT from cycle 2.
  - `busy_i` falls in cycle k: done high in cycle k+1.
  - Minimum request-to-done is 3 cycles.
- An edge seen in the same cycle the watchdog expires counts as success (err=0).
- A `busy_i` fall during IDLE, ISSUE or RESP is ignored; `prev_busy` still tracks `busy_i`.
- `to_cnt` clears on entry to WAIT.
- `nrst` asserted mid-transaction: immediately return to reset values; the transaction is abandoned and no done is issued.

## Structure
- Package `t07_mem_arb_pkg`: `arb_state_t` enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and the `rwi` encoding constants (RWI_IDLE, RWI_READ, RWI_WRITE, RWI_FETCH).
- Sub-module `t07_busy_edge`: registers `busy_i` and outputs the falling-edge pulse.

## Test plan
- Fetch only: `f_addr`=0x100, `busy_i` high cycles 2–5 then low → `rwi_o`=11 and `sel_o`=1 from cycle 1; `f_done_o` in cycle 7 with `f_rdata_o`=`rdata_i`.
- Store only: `d_we`=1, addr 0x2000, wdata 0xCAFEF00D → `rwi_o`=01, `sel_o`=0, `wdata_o`=0xCAFEF00D held through WAIT; `d_done_o` pulses; `d_rdata_o`=0.
- Simultaneous fetch+load, both held continuously → grants D,D,D,D,F (STARVE_LIMIT=4); `starve_cnt` returns to 0 after the fetch grant.
- `busy_i` stuck high with TIMEOUT=8 → done + `err_o`=1 exactly 8 cycles after entering WAIT; rdata=0; next request is served normally.
- `nrst` pulsed low in WAIT → all outputs at reset values within the same cycle; no done pulse; a subsequent fetch completes normally.
- `busy_i` falls in IDLE with no request → no state change and no done.

Source files
------------

// File: rtl/t07_mem_arb_pkg.sv
// t07_mem_arb_pkg: shared FSM state and bus command encodings for the memory arbiter
package t07_mem_arb_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3
  } arb_state_t;
  localparam logic [1:0] RWI_IDLE  = 2'b00;
  localparam logic [1:0] RWI_READ  = 2'b10;
  localparam logic [1:0] RWI_WRITE = 2'b01;
  localparam logic [1:0] RWI_FETCH = 2'b11;
endpackage

// File: rtl/t07_busy_edge.sv
// t07_busy_edge: registers bus busy and flags its high-to-low transition
module t07_busy_edge (
  input  logic clk,
  input  logic nrst,
  input  logic busy_i,
  output logic fall_o
);
  logic prev_busy_q;
  // previous-cycle busy, tracked in every state
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) prev_busy_q <= 1'b0;
    else prev_busy_q <= busy_i;
  assign fall_o = prev_busy_q & ~busy_i;
endmodule

// File: rtl/t07_mem_arbiter.sv
// t07_mem_arbiter: shares one memory bus between instruction fetch and load/store requesters
module t07_mem_arbiter
  import t07_mem_arb_pkg::*;
#(
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        busy_i,
  input  logic [31:0] rdata_i,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_done_o,
  output logic [31:0] f_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_done_o,
  output logic [31:0] d_rdata_o,
  output logic        err_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [1:0]  rwi_o,
  output logic        sel_o,
  output logic [2:0]  state_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  arb_state_t  state_q, state_d;
  logic        sel_q, we_q, err_q, fall;
  logic [31:0] addr_q, wdata_q, f_rdata_q, d_rdata_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] to_q;
  t07_busy_edge u_edge (
    .clk    (clk),
    .nrst   (nrst),
    .busy_i (busy_i),
    .fall_o (fall)
  );
  wire grant   = f_req_i | d_req_i;
  wire grant_f = f_req_i & (~d_req_i | (starve_q == SW'(STARVE_LIMIT)));
  wire expire  = to_q == TW'(TIMEOUT - 1);
  wire done    = state_q == WAIT && (fall || expire);
  wire [31:0] cap = (fall & ~we_q) ? rdata_i : '0;
  // state register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state_q <= IDLE;
    else state_q <= state_d;
  // next state: a completion edge wins over a simultaneous watchdog expiry
  always_comb
    state_d = state_q == IDLE  ? (grant ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? ((fall || expire) ? RESP : WAIT) : IDLE;
  // transaction latch, starvation and watchdog counters, read-data return
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sel_q     <= 1'b1;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      to_q      <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && grant) begin
        sel_q    <= grant_f;
        we_q     <= ~grant_f & d_we_i;
        addr_q   <= grant_f ? f_addr_i : d_addr_i;
        wdata_q  <= grant_f ? '0 : d_wdata_i;
        starve_q <= grant_f ? '0 :
                    (f_req_i && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
      end
      to_q <= state_q == WAIT ? to_q + TW'(1) : '0;
      if (done) begin
        err_q <= ~fall;
        if (sel_q) f_rdata_q <= cap;
        else d_rdata_q <= cap;
      end
    end
  // bus and requester outputs decoded from state and the latched transaction
  always_comb begin
    rwi_o    = (state_q == ISSUE || state_q == WAIT) ?
               (sel_q ? RWI_FETCH : we_q ? RWI_WRITE : RWI_READ) : RWI_IDLE;
    addr_o   = (state_q == ISSUE || state_q == WAIT) ? addr_q : '0;
    wdata_o  = (state_q == ISSUE || state_q == WAIT) ? wdata_q : '0;
    sel_o    = state_q == IDLE ? 1'b1 : sel_q;
    f_done_o = state_q == RESP & sel_q;
    d_done_o = state_q == RESP & ~sel_q;
    err_o    = state_q == RESP & err_q;
    state_o  = state_q;
  end
  assign f_rdata_o = f_rdata_q;
  assign d_rdata_o = d_rdata_q;
endmodule

// File: tb/tb_t07_mem_arbiter.sv
// tb_t07_mem_arbiter: directed and randomized transactions against a transaction-level model
module tb_t07_mem_arbiter;
  localparam int TO = 8;
  localparam int SL = 4;
  logic        clk = 0, nrst = 0, busy_i = 0, f_req_i = 0, d_req_i = 0, d_we_i = 0;
  logic [31:0] rdata_i = 0, f_addr_i = 0, d_addr_i = 0, d_wdata_i = 0;
  logic        f_done_o, d_done_o, err_o, sel_o;
  logic [31:0] f_rdata_o, d_rdata_o, addr_o, wdata_o;
  logic [1:0]  rwi_o;
  logic [2:0]  state_o;
  int vectors = 0, miscompares = 0;
  int starve = 0;
  logic [31:0] m_frd = 0, m_drd = 0;

  t07_mem_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .nrst(nrst), .busy_i(busy_i), .rdata_i(rdata_i),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_done_o(f_done_o), .f_rdata_o(f_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_done_o(d_done_o), .d_rdata_o(d_rdata_o), .err_o(err_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rwi_o(rwi_o), .sel_o(sel_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_rwi"}, 32'(rwi_o), 0);
    chk({tag, "_addr"}, addr_o, 0);
    chk({tag, "_sel"}, 32'(sel_o), 1);
    chk({tag, "_done"}, {30'b0, f_done_o, d_done_o}, 0);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      step;
      f_req_i = 0; d_req_i = 0; busy_i = b; rdata_i = $urandom;
      #1;
      chk_quiet("idle");
    end
  endtask

  // one transaction from an IDLE cycle to its done cycle; busy_i is high for
  // 'hold' cycles from the first WAIT cycle, then falls with the read data
  task automatic txn(input bit fr, input bit dr, input bit we, input logic [31:0] fa,
                     input logic [31:0] da, input logic [31:0] wd, input logic [31:0] rd,
                     input int hold);
    bit gf, er;
    logic [1:0] cmd;
    logic [31:0] a;
    int resp;
    gf   = fr && (!dr || starve == SL);
    starve = gf ? 0 : (fr ? (starve == SL ? SL : starve + 1) : starve);
    cmd  = gf ? 2'b11 : (we ? 2'b01 : 2'b10);
    a    = gf ? fa : da;
    er   = hold >= TO;
    resp = er ? 2 + TO : 3 + hold;
    for (int c = 0; c <= resp; c++) begin
      step;
      f_req_i = fr; d_req_i = dr; d_we_i = we;
      f_addr_i = fa; d_addr_i = da; d_wdata_i = wd;
      busy_i  = c >= 2 && c < 2 + hold;
      rdata_i = (c == 2 + hold) ? rd : $urandom;
      #1;
      if (c == 0) chk_quiet("req");
      else if (c < resp) begin
        chk("bus_state", 32'(state_o), c == 1 ? 1 : 2);
        chk("bus_rwi", 32'(rwi_o), 32'(cmd));
        chk("bus_sel", 32'(sel_o), 32'(gf));
        chk("bus_addr", addr_o, a);
        if (!gf && we) chk("bus_wdata", wdata_o, wd);
        chk("bus_done", {30'b0, f_done_o, d_done_o}, 0);
      end else begin
        if (gf) m_frd = er ? 0 : rd;
        else m_drd = (er || we) ? 0 : rd;
        chk("resp_state", 32'(state_o), 3);
        chk("resp_rwi", 32'(rwi_o), 0);
        chk("resp_addr", addr_o, 0);
        chk("resp_fdone", 32'(f_done_o), 32'(gf));
        chk("resp_ddone", 32'(d_done_o), 32'(!gf));
        chk("resp_err", 32'(err_o), 32'(er));
        chk("resp_frdata", f_rdata_o, m_frd);
        chk("resp_drdata", d_rdata_o, m_drd);
      end
    end
  endtask

  initial begin
    // reset state
    #1;
    chk_quiet("rst");
    chk("rst_frdata", f_rdata_o, 0);
    chk("rst_drdata", d_rdata_o, 0);
    step;
    nrst = 1;
    idle(2, 0);
    // fetch only, busy high for four WAIT cycles
    txn(1, 0, 0, 32'h100, 0, 0, 32'h1234_5678, 4);
    // store only
    txn(0, 1, 1, 0, 32'h2000, 32'hCAFE_F00D, 32'hDEAD_BEEF, 3);
    // load only, minimum latency
    txn(0, 1, 0, 0, 32'h3000, 0, 32'hA5A5_0001, 1);
    // fetch and load held together: D,D,D,D,F then data again
    for (int i = 0; i < 6; i++)
      txn(1, 1, 0, 32'h400 + 32'(i), 32'h800 + 32'(i), 0, $urandom, 2);
    idle(1, 0);
    // watchdog: edge coinciding with expiry succeeds, stuck busy aborts
    txn(0, 1, 0, 0, 32'h44, 0, 32'h7777_0000, TO - 1);
    txn(1, 0, 0, 32'h48, 0, 0, 32'h9999_1111, 100);
    txn(0, 1, 0, 0, 32'h4C, 0, 32'h5555_2222, 100);
    txn(1, 0, 0, 32'h50, 0, 0, 32'h0BAD_F00D, 2);
    // busy falling while idle is ignored
    idle(1, 1);
    idle(3, 0);
    // asynchronous reset while waiting abandons the transaction
    step; f_req_i = 1; f_addr_i = 32'h60; #1;
    step; #1;
    step; busy_i = 1; #1;
    chk("rstw_state", 32'(state_o), 2);
    step; nrst = 0; #1;
    m_frd = 0; m_drd = 0; starve = 0;
    chk_quiet("rstw");
    chk("rstw_wdata", wdata_o, 0);
    chk("rstw_frdata", f_rdata_o, 0);
    chk("rstw_drdata", d_rdata_o, 0);
    step; nrst = 1; f_req_i = 0; busy_i = 0; #1;
    chk_quiet("rstw_rel");
    idle(2, 0);
    txn(1, 0, 0, 32'h64, 0, 0, 32'hFEED_0064, 3);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit fr, dr;
      fr = $urandom_range(0, 1);
      dr = fr ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(fr, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
          $urandom_range(1, TO + 1));
      if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
